id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand preparation for the pipelined MIPS core.
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Drives op1/op2/ALUCtrl straight into the ALU. Shift convention: op1 = shift amount, op2 = shifted value.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of saturating bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash instruction entering EX (branch/jump redirect)
- id_valid  in  1  ID holds a real instruction
- id_alu_ctrl  in  4  ALU op code (ADD=0..SLT=14)
- id_rs, id_rt, id_rd  in  5 each  source/destination register numbers
- id_rs_data, id_rt_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  pre-extended immediate
- id_shamt  in  5  shift amount field
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs/rt
- id_use_imm, id_use_shamt  in  1 each  op2 = imm / op1 = shamt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  XLEN  EX/MEM forwarding source
- memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  XLEN  MEM/WB forwarding source
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- alu_op1, alu_op2  out  XLEN each  ALU operands (combinational from EX register + forwarding)
- alu_ctrl  out  4  registered ALU op
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control
- ex_rd  out  5  registered destination
- ex_store_data  out  XLEN  forwarded rt value for stores
- bubble_count  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (rst_n low, async):
  - all EX registers cleared; ex_valid=0; all control bits=0; alu_ctrl=0; ex_rd=0.
  - alu_op1/op2 evaluate from zeroed registers (=0); bubble_count=0.
- Load-use hazard, combinational:
  - hz = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - stall_id = hz & ~flush.
- Clock edge, priority flush > hz > load:
  - flush: EX loads a bubble (ex_valid=0, all write/mem controls 0).
  - hz: EX loads a bubble; ID contents are held by upstream via stall_id; bubble_count increments, saturating at all-ones.
  - otherwise: EX loads all id_* fields; ex_valid=id_valid; when id_valid=0 all control bits are forced 0.
- Bubble encoding: alu_ctrl=0, ex_rd=0. A bubble must never write a register or memory.
- Forwarding (rs path; rt path identical using rt), combinational, evaluated on registered EX fields:
  - if exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs: value = exmem_result
  - else if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs: value = memwb_result
  - else: value = registered rs_data
  - Register 0 is never forwarded. EX/MEM wins when both sources match.
- Operand muxing:
  - alu_op1 = ex_use_shamt ? {27'b0, shamt} : fwd_rs
  - alu_op2 = ex_use_imm ? imm : fwd_rt
  - ex_store_data = fwd_rt, always (stores use imm for op2 and rt for data).
- Latency: one cycle from ID capture to ALU operands; forwarding adds no cycles.
- Reset mid-stall or mid-flush: the registered state clears immediately; stall_id follows the inputs combinationally.

Test Plan:
- Reset: rst_n=0 mid-operation -> ex_valid=0, ex_reg_write=0, bubble_count=0, alu_op1=alu_op2=0, with no clock edge required.
- Forward priority: ADD rs=5, rt=6 in EX (rs_data=1, rt_data=2); exmem rd=5 result=0x100; memwb rd=5 result=0x200; memwb rd=6 result=0x7 -> alu_op1=0x100, alu_op2=0x7.
- $zero guard: EX rs=0, rs_data=0; exmem_reg_write=1, rd=0, result=0xDEAD -> alu_op1=0.
- Load-use: EX holds LW rd=8; ID ADD rs=8 -> stall_id=1. Next edge: ex_valid=0, bubble_count=1. Following edge with exmem forwarding rd=8 -> ADD reaches EX with the forwarded value.
- Flush+hazard same cycle: conditions as the load-use case, plus flush=1 -> stall_id=0; EX gets a bubble; bubble_count unchanged.
- Shift/imm muxing: SLL, shamt=4, rt_data=0x1 -> alu_op1=4, alu_op2=0x1. SW imm=0x10, rt fwd 0xAB -> alu_op2=0x10, ex_store_data=0xAB. Saturation: preload counter near max, force hazards -> holds at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_alu_ctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_shamt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_use_imm,
  input  logic             id_use_shamt,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             stall_id,
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [3:0]       alu_ctrl,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [CNT_W-1:0] bubble_count
);
  logic             valid_q, valid_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [XLEN-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic             use_imm_q, use_imm_d, use_shamt_q, use_shamt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz, bubble;
  logic [XLEN-1:0]  fwd_rs, fwd_rt;
  always_comb begin
    hz = valid_q & ctrl_q[2] & (rd_q != 5'd0) & id_valid &
         ((id_uses_rs & (id_rs == rd_q)) | (id_uses_rt & (id_rt == rd_q)));
    stall_id = hz & ~flush;
    bubble = flush | hz;
    valid_d = bubble ? 1'b0 : id_valid;
    ctrl_d = (bubble | ~id_valid) ? 4'd0 : {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg};
    alu_ctrl_d = bubble ? 4'd0 : id_alu_ctrl;
    rs_d = bubble ? 5'd0 : id_rs;
    rt_d = bubble ? 5'd0 : id_rt;
    rd_d = bubble ? 5'd0 : id_rd;
    shamt_d = bubble ? 5'd0 : id_shamt;
    rs_data_d = bubble ? '0 : id_rs_data;
    rt_data_d = bubble ? '0 : id_rt_data;
    imm_d = bubble ? '0 : id_imm;
    use_imm_d = bubble ? 1'b0 : id_use_imm;
    use_shamt_d = bubble ? 1'b0 : id_use_shamt;
    cnt_d = (stall_id && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= 4'd0;
      alu_ctrl_q  <= 4'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rd_q        <= 5'd0;
      shamt_q     <= 5'd0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      use_shamt_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      shamt_q     <= shamt_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      use_shamt_q <= use_shamt_d;
      cnt_q       <= cnt_d;
    end
  end
  // EX/MEM is the younger result, so it takes precedence; register 0 is hardwired and never forwarded
  always_comb begin
    fwd_rs = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs_q) ? exmem_result :
             (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs_q) ? memwb_result : rs_data_q;
    fwd_rt = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rt_q) ? exmem_result :
             (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rt_q) ? memwb_result : rt_data_q;
    alu_op1 = use_shamt_q ? {{(XLEN-5){1'b0}}, shamt_q} : fwd_rs;
    alu_op2 = use_imm_q ? imm_q : fwd_rt;
  end
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = ctrl_q[3];
  assign ex_mem_read   = ctrl_q[2];
  assign ex_mem_write  = ctrl_q[1];
  assign ex_mem_to_reg = ctrl_q[0];
  assign ex_rd         = rd_q;
  assign bubble_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scenario tasks with a queue of expected ALU operands per captured instruction.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic id_valid, id_uses_rs, id_uses_rt, id_use_imm, id_use_shamt;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [3:0] id_alu_ctrl;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt, exmem_rd, memwb_rd;
  logic [XLEN-1:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic exmem_reg_write, memwb_reg_write;
  logic stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [XLEN-1:0] alu_op1, alu_op2, ex_store_data;
  logic [3:0] alu_ctrl;
  logic [4:0] ex_rd;
  logic [CNT_W-1:0] bubble_count;
  typedef struct {logic [XLEN-1:0] op1; logic [XLEN-1:0] op2;} exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0;
  int exp_cnt = 0;
  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall_id(stall_id), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .bubble_count(bubble_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    flush = 0; id_valid = 0; id_alu_ctrl = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_use_imm = 0; id_use_shamt = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask
  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [XLEN-1:0] rsd, input logic [XLEN-1:0] rtd);
    clear_inputs();
    id_valid = 1; id_alu_ctrl = 4'd0; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1;
  endtask
  task automatic drive_lw(input logic [4:0] rd);
    clear_inputs();
    id_valid = 1; id_rs = 5'd1; id_rd = rd; id_rt = rd; id_imm = 32'h4; id_use_imm = 1;
    id_uses_rs = 1; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    drive_add(5'd3, 5'd4, 5'd7, 32'h11, 32'h22);
    step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || bubble_count !== '0 || alu_op1 !== 0 || alu_op2 !== 0 || ex_rd !== 0) begin
      fails++;
      $display("FAIL reset: valid=%b rw=%b cnt=%0d op1=%h op2=%h rd=%0d, want all 0", ex_valid, ex_reg_write, bubble_count, alu_op1, alu_op2, ex_rd);
    end
    exp_cnt = 0;
    clear_inputs();
    #3 rst_n = 1'b1;
    step();
  endtask
  task automatic test_forward_priority();
    drive_add(5'd5, 5'd6, 5'd10, 32'h1, 32'h2);
    sb.push_back('{op1: 32'h100, op2: 32'h2});
    step();
    clear_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h100;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h200;
    #1;
    e = sb.pop_front();
    tests++;
    if (alu_op1 !== e.op1 || alu_op2 !== e.op2) begin
      fails++;
      $display("FAIL fwd_exmem_wins: op1=%h op2=%h, want %h %h", alu_op1, alu_op2, e.op1, e.op2);
    end
    memwb_rd = 5'd6; memwb_result = 32'h7;
    #1;
    tests++;
    if (alu_op1 !== 32'h100 || alu_op2 !== 32'h7 || ex_store_data !== 32'h7) begin
      fails++;
      $display("FAIL fwd_memwb_rt: op1=%h op2=%h st=%h, want 100 7 7", alu_op1, alu_op2, ex_store_data);
    end
  endtask
  task automatic test_zero_guard();
    drive_add(5'd0, 5'd0, 5'd9, 32'h0, 32'h0);
    sb.push_back('{op1: 32'h0, op2: 32'h0});
    step();
    clear_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
    #1;
    e = sb.pop_front();
    tests++;
    if (alu_op1 !== e.op1 || alu_op2 !== e.op2) begin
      fails++;
      $display("FAIL zero_guard: op1=%h op2=%h, want %h %h", alu_op1, alu_op2, e.op1, e.op2);
    end
  endtask
  task automatic test_load_use();
    drive_lw(5'd8);
    step();
    drive_add(5'd8, 5'd9, 5'd12, 32'h3, 32'h4);
    #1;
    tests++;
    if (stall_id !== 1'b1) begin
      fails++;
      $display("FAIL load_use_stall: stall_id=%b, want 1", stall_id);
    end
    step();
    if (exp_cnt < 15) exp_cnt++;
    tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || bubble_count !== CNT_W'(exp_cnt) || stall_id !== 1'b0) begin
      fails++;
      $display("FAIL load_use_bubble: valid=%b rw=%b mr=%b cnt=%0d stall=%b, want 0 0 0 %0d 0", ex_valid, ex_reg_write, ex_mem_read, bubble_count, stall_id, exp_cnt);
    end
    sb.push_back('{op1: 32'h55, op2: 32'h4});
    step();
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'h55;
    #1;
    e = sb.pop_front();
    tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || alu_op1 !== e.op1 || alu_op2 !== e.op2) begin
      fails++;
      $display("FAIL load_use_fwd: valid=%b rd=%0d op1=%h op2=%h, want 1 12 %h %h", ex_valid, ex_rd, alu_op1, alu_op2, e.op1, e.op2);
    end
  endtask
  task automatic test_flush_hazard();
    drive_lw(5'd8);
    step();
    drive_add(5'd1, 5'd8, 5'd13, 32'h3, 32'h4);
    flush = 1;
    #1;
    tests++;
    if (stall_id !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall: stall_id=%b, want 0", stall_id);
    end
    step();
    tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || alu_ctrl !== 4'd0 || bubble_count !== CNT_W'(exp_cnt)) begin
      fails++;
      $display("FAIL flush_bubble: valid=%b rw=%b rd=%0d ctrl=%0d cnt=%0d, want 0 0 0 0 %0d", ex_valid, ex_reg_write, ex_rd, alu_ctrl, bubble_count, exp_cnt);
    end
    clear_inputs();
  endtask
  task automatic test_shift_imm();
    clear_inputs();
    id_valid = 1; id_alu_ctrl = 4'd8; id_rt = 5'd2; id_rd = 5'd14; id_rt_data = 32'h1;
    id_shamt = 5'd4; id_use_shamt = 1; id_uses_rt = 1; id_reg_write = 1;
    sb.push_back('{op1: 32'h4, op2: 32'h1});
    step();
    e = sb.pop_front();
    tests++;
    if (alu_op1 !== e.op1 || alu_op2 !== e.op2 || alu_ctrl !== 4'd8) begin
      fails++;
      $display("FAIL shift: op1=%h op2=%h ctrl=%0d, want %h %h 8", alu_op1, alu_op2, alu_ctrl, e.op1, e.op2);
    end
    clear_inputs();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd3; id_rs_data = 32'h1000; id_rt_data = 32'h0;
    id_imm = 32'h10; id_use_imm = 1; id_uses_rs = 1; id_uses_rt = 1; id_mem_write = 1;
    sb.push_back('{op1: 32'h1000, op2: 32'h10});
    step();
    clear_inputs();
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hAB;
    #1;
    e = sb.pop_front();
    tests++;
    if (alu_op1 !== e.op1 || alu_op2 !== e.op2 || ex_store_data !== 32'hAB || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin
      fails++;
      $display("FAIL store: op1=%h op2=%h st=%h mw=%b rw=%b, want %h %h ab 1 0", alu_op1, alu_op2, ex_store_data, ex_mem_write, ex_reg_write, e.op1, e.op2);
    end
  endtask
  task automatic test_invalid_id();
    drive_add(5'd2, 5'd3, 5'd4, 32'h9, 32'h9);
    id_valid = 0; id_mem_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    step();
    tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 || ex_mem_to_reg !== 1'b0) begin
      fails++;
      $display("FAIL invalid_id: valid=%b rw=%b mr=%b mw=%b m2r=%b, want all 0", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg);
    end
    clear_inputs();
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive_lw(5'd20);
      step();
      drive_add(5'd20, 5'd21, 5'd22, 32'h0, 32'h0);
      #1;
      if (stall_id !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL sat_stall: iter %0d stall_id=%b, want 1", i, stall_id);
      end
      step();
      if (exp_cnt < 15) exp_cnt++;
    end
    tests++;
    if (bubble_count !== 4'hF || exp_cnt != 15) begin
      fails++;
      $display("FAIL saturation: cnt=%h, want f", bubble_count);
    end
    clear_inputs();
  endtask
  task automatic test_back_to_back();
    logic [XLEN-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      drive_add(5'(i + 1), 5'(i + 10), 5'(i + 20), a, b);
      sb.push_back('{op1: a, op2: b});
      step();
      e = sb.pop_front();
      tests++;
      if (alu_op1 !== e.op1 || alu_op2 !== e.op2 || ex_rd !== 5'(i + 20) || ex_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b[%0d]: op1=%h op2=%h rd=%0d v=%b, want %h %h %0d 1", i, alu_op1, alu_op2, ex_rd, ex_valid, e.op1, e.op2, i + 20);
      end
    end
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_forward_priority();
    test_zero_guard();
    test_load_use();
    test_flush_hazard();
    test_shift_imm();
    test_invalid_id();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
